// File: rtl/biquad_pkg.sv
// rtl/biquad_pkg.sv - shared types, constants and FSM states for the biquad core
package biquad_pkg;

    localparam int SAMPLE_WIDTH = 24;
    localparam int COEF_FRAC    = 16;
    localparam int ACC_WIDTH    = 52;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic signed [SAMPLE_WIDTH-1:0] coef_t;
    typedef logic signed [ACC_WIDTH-1:0]    acc_t;

    localparam acc_t ROUND_HALF = acc_t'(2 ** (COEF_FRAC - 1));
    localparam acc_t SAT_MAX    = acc_t'(2 ** (SAMPLE_WIDTH - 1) - 1);
    localparam acc_t SAT_MIN    = acc_t'(-(2 ** (SAMPLE_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        MAC,
        ROUND
    } state_t;

endpackage

// File: rtl/biquad_filter_core_round_sat.sv
// rtl/biquad_filter_core_round_sat.sv - round-half-up, shift and saturate accumulator to a Q1.23 sample
module round_sat
    import biquad_pkg::*;
#(
    parameter int ACC_W    = ACC_WIDTH,
    parameter int SAMPLE_W = SAMPLE_WIDTH,
    parameter int FRAC     = COEF_FRAC
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [SAMPLE_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] HALF = ONE <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAXV = (ONE <<< (SAMPLE_W - 1)) - ONE;
    localparam logic signed [ACC_W-1:0] MINV = -(ONE <<< (SAMPLE_W - 1));

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        sum     = acc + HALF;
        shifted = sum >>> FRAC;
        if (shifted > MAXV) begin
            result = MAXV[SAMPLE_W-1:0];
        end else if (shifted < MINV) begin
            result = MINV[SAMPLE_W-1:0];
        end else begin
            result = shifted[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/biquad_filter_core.sv
// rtl/biquad_filter_core.sv - Direct Form I biquad with one shared multiplier and shadowed coefficients
module biquad_filter_core
    import biquad_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int COEF_FRAC    = 16,
    parameter int ACC_WIDTH    = 52
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    coef_valid,
    input  logic [SAMPLE_WIDTH-1:0] b0,
    input  logic [SAMPLE_WIDTH-1:0] b1,
    input  logic [SAMPLE_WIDTH-1:0] b2,
    input  logic [SAMPLE_WIDTH-1:0] a1,
    input  logic [SAMPLE_WIDTH-1:0] a2,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [SAMPLE_WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic                    coef_pending
);

    localparam int PROD_WIDTH = 2 * SAMPLE_WIDTH;

    state_t state, state_next, phase;
    logic   pending, clear_flag, accept, commit, op_sub;
    logic [2:0] tap;

    logic signed [SAMPLE_WIDTH-1:0] sh_b0, sh_b1, sh_b2, sh_a1, sh_a2;
    logic signed [SAMPLE_WIDTH-1:0] ac_b0, ac_b1, ac_b2, ac_a1, ac_a2;
    logic signed [SAMPLE_WIDTH-1:0] x0, x1, x2, y1, y2;
    logic signed [SAMPLE_WIDTH-1:0] op_coef, op_data, rounded;
    logic signed [PROD_WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext, acc;

    // A pending shadow set in IDLE turns that cycle into the commit cycle.
    assign phase        = (state == IDLE && pending) ? COMMIT : state;
    assign in_ready     = (phase == IDLE);
    assign accept       = in_valid && in_ready;
    assign commit       = (phase == COMMIT);
    assign coef_pending = pending;

    always_comb begin
        op_coef = ac_b0;
        op_data = x0;
        op_sub  = 1'b0;
        case (tap)
            3'd0: begin op_coef = ac_b0; op_data = x0; end
            3'd1: begin op_coef = ac_b1; op_data = x1; end
            3'd2: begin op_coef = ac_b2; op_data = x2; end
            3'd3: begin op_coef = ac_a1; op_data = y1; op_sub = 1'b1; end
            3'd4: begin op_coef = ac_a2; op_data = y2; op_sub = 1'b1; end
            default: begin op_coef = ac_b0; op_data = x0; end
        endcase
    end

    assign prod     = op_coef * op_data;
    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

    round_sat #(
        .ACC_W    (ACC_WIDTH),
        .SAMPLE_W (SAMPLE_WIDTH),
        .FRAC     (COEF_FRAC)
    ) u_round_sat (
        .acc    (acc),
        .result (rounded)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (tap == 3'd4) state_next = ROUND;
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            clear_flag <= 1'b0;
            tap        <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            {sh_b0, sh_b1, sh_b2, sh_a1, sh_a2} <= '0;
            {ac_b0, ac_b1, ac_b2, ac_a1, ac_a2} <= '0;
            {x0, x1, x2, y1, y2}                <= '0;
        end else begin
            out_valid <= 1'b0;

            if (commit) begin
                {ac_b0, ac_b1, ac_b2, ac_a1, ac_a2} <= {sh_b0, sh_b1, sh_b2, sh_a1, sh_a2};
                pending <= 1'b0;
            end
            // A fresh set arriving in the commit cycle keeps pending for a second commit.
            if (coef_valid) begin
                {sh_b0, sh_b1, sh_b2, sh_a1, sh_a2} <= {b0, b1, b2, a1, a2};
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clear || clear_flag) begin
                        {x1, x2, y1, y2} <= '0;
                    end
                    clear_flag <= 1'b0;
                    if (accept) begin
                        x0  <= in_data;
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= op_sub ? (acc - prod_ext) : (acc + prod_ext);
                    tap <= tap + 3'd1;
                    if (clear) clear_flag <= 1'b1;
                end
                ROUND: begin
                    out_data  <= rounded;
                    out_valid <= 1'b1;
                    x2        <= x1;
                    x1        <= x0;
                    y2        <= y1;
                    y1        <= rounded;
                    if (clear) clear_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
